// File: rtl/io_pkg.sv
// Shared register-window definitions for the switch input port.
package io_pkg;

  localparam logic [3:0] SW_ADDR_STABLE = 4'h0;
  localparam logic [3:0] SW_ADDR_CHG    = 4'h4;
  localparam logic [3:0] SW_ADDR_EDGE   = 4'h8;
  localparam logic [3:0] SW_ADDR_MASK   = 4'hC;

  typedef enum logic [3:0] {
    AddrStable = SW_ADDR_STABLE,
    AddrChg    = SW_ADDR_CHG,
    AddrEdge   = SW_ADDR_EDGE,
    AddrMask   = SW_ADDR_MASK
  } sw_reg_addr_e;

  // Word-align a byte offset; the low two bits never select a register.
  function automatic sw_reg_addr_e sw_word_addr(input logic [3:0] addr);
    return sw_reg_addr_e'({addr[3:2], 2'b00});
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, persistence counter and debounced level.
// toggle is high in the cycle whose clock edge flips the debounced level.
module sw_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic stable,
  output logic toggle
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  assign toggle = (sync2 != stable) && (cnt == CNT_MAX);

  // Synchronise, then accept a new level only after it persists long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (toggle) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sw_input_port.sv
// Switch bank receiver: per-bit debounce, sticky change flags, toggle counter
// on bit 0, and a 4-word LSU register window with a maskable interrupt.
module sw_input_port
  import io_pkg::*;
#(
  parameter int unsigned NUM_SW          = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_SW-1:0] i_io_sw,
  input  logic              i_rd_en,
  input  logic              i_wr_en,
  input  logic [3:0]        i_addr,
  input  logic [31:0]       i_wr_data,
  output logic [31:0]       o_rd_data,
  output logic              o_rd_vld,
  output logic [NUM_SW-1:0] o_sw_stable,
  output logic              o_irq
);

  logic [NUM_SW-1:0] toggle;
  logic [NUM_SW-1:0] chg_flags_q;
  logic [NUM_SW-1:0] irq_mask_q;
  logic [31:0]       edge_cnt_q;
  logic [31:0]       rd_mux;
  sw_reg_addr_e      reg_addr;
  logic              unused_bits;

  assign unused_bits = ^{i_addr[1:0], i_wr_data};
  assign reg_addr    = sw_word_addr(i_addr);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk   (i_clk),
      .rst_n (i_reset),
      .sw_raw(i_io_sw[i]),
      .stable(o_sw_stable[i]),
      .toggle(toggle[i])
    );
  end

  // Read mux sees register values before this edge's updates.
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      AddrStable: rd_mux = 32'(o_sw_stable);
      AddrChg:    rd_mux = 32'(chg_flags_q);
      AddrEdge:   rd_mux = edge_cnt_q;
      AddrMask:   rd_mux = 32'(irq_mask_q);
      default:    rd_mux = '0;
    endcase
  end

  // Flags, counter, mask and output registers. A toggle on the same edge as a
  // read-clear wins so the new event survives.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      chg_flags_q <= '0;
      irq_mask_q  <= '0;
      edge_cnt_q  <= '0;
      o_rd_data   <= '0;
      o_rd_vld    <= 1'b0;
      o_irq       <= 1'b0;
    end else begin
      if (i_rd_en && reg_addr == AddrChg) begin
        chg_flags_q <= toggle;
      end else begin
        chg_flags_q <= chg_flags_q | toggle;
      end
      if (toggle[0]) begin
        edge_cnt_q <= edge_cnt_q + 32'd1;
      end
      if (i_wr_en && reg_addr == AddrMask) begin
        irq_mask_q <= i_wr_data[NUM_SW-1:0];
      end
      if (i_rd_en) begin
        o_rd_data <= rd_mux;
      end
      o_rd_vld <= i_rd_en;
      o_irq    <= |(chg_flags_q & irq_mask_q);
    end
  end

endmodule

// File: tb/tb_sw_input_port.sv
// Directed self-checking bench for sw_input_port (NUM_SW=32, DEBOUNCE_CYCLES=4).
module tb_sw_input_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sw = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rd_vld;
  logic [31:0] sw_stable;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sw_input_port #(
    .NUM_SW         (32),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_io_sw    (sw),
    .i_rd_en    (rd_en),
    .i_wr_en    (wr_en),
    .i_addr     (addr),
    .i_wr_data  (wr_data),
    .o_rd_data  (rd_data),
    .o_rd_vld   (rd_vld),
    .o_sw_stable(sw_stable),
    .o_irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle read strobe; checks data/valid after the edge and valid drop after.
  task automatic do_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_vld"}, 32'(rd_vld), 32'd1);
    check(tag, rd_data, exp);
    tick();
    check({tag, "_vld_drop"}, 32'(rd_vld), 32'd0);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    addr    = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_stable", sw_stable, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_vld", 32'(rd_vld), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-count: three edges seen, reset before the fourth
    sw = 32'h1;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("midrst_stable", sw_stable, 32'h0);
    check("midrst_irq", 32'(irq), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("rerun_edge5", sw_stable, 32'h0);
    tick();
    check("rerun_edge6", sw_stable, 32'h1);

    // Clean step to 0xA5 (bit 0 already high)
    sw = 32'hA5;
    tick(5);
    check("step_edge5", sw_stable, 32'h1);
    tick();
    check("step_edge6", sw_stable, 32'hA5);
    check("step_irq", 32'(irq), 32'd0);
    do_read("clr_a5", 4'h4, 32'hA5);

    // Bounce on bit 3, then hold high
    sw = 32'hAD; tick();
    sw = 32'hA5; tick();
    sw = 32'hAD; tick();
    sw = 32'hA5; tick();
    sw = 32'hAD;
    tick(5);
    check("bounce_edge5", sw_stable, 32'hA5);
    tick();
    check("bounce_edge6", sw_stable, 32'hAD);
    do_read("bounce_edgecnt", 4'h8, 32'h1);
    do_read("bounce_flags", 4'h4, 32'h8);

    // Flags on bit 0 and bit 31
    sw = 32'h8000_00AC;
    tick(6);
    check("flags_stable", sw_stable, 32'h8000_00AC);
    do_read("flags_read", 4'h5, 32'h8000_0001);
    do_read("flags_reread", 4'h4, 32'h0);
    do_read("stable_read", 4'h0, 32'h8000_00AC);

    // Write to read-only offset is ignored
    do_write(4'h0, 32'hFFFF_FFFF);
    do_read("ro_write", 4'h0, 32'h8000_00AC);

    // Race: read-clear on the edge bit 5 stabilises
    sw = 32'h8000_008C;
    tick(5);
    rd_en = 1'b1;
    addr  = 4'h4;
    tick();
    rd_en = 1'b0;
    check("race_stable", sw_stable, 32'h8000_008C);
    check("race_data", rd_data, 32'h0);
    do_read("race_reread", 4'h4, 32'h20);

    // IRQ path
    do_write(4'hC, 32'h1);
    do_read("mask_read", 4'hC, 32'h1);
    sw = 32'h8000_008D;
    tick(6);
    check("irq_flag_edge", 32'(irq), 32'd0);
    tick();
    check("irq_next_edge", 32'(irq), 32'd1);

    // Simultaneous read and write of the mask
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    addr    = 4'hC;
    wr_data = 32'h0;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("rdwr_old_mask", rd_data, 32'h1);
    check("rdwr_irq_lag", 32'(irq), 32'd1);
    tick();
    check("rdwr_irq_off", 32'(irq), 32'd0);
    do_read("rdwr_new_mask", 4'hC, 32'h0);
    do_read("edgecnt_3", 4'h8, 32'h3);

    // edge_cnt wrap
    @(negedge clk);
    force dut.edge_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.edge_cnt_q;
    do_read("edgecnt_forced", 4'h8, 32'hFFFF_FFFF);
    sw = 32'h8000_008C;
    tick(6);
    do_read("edgecnt_wrap", 4'h8, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
